// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with sized, little-endian loads/stores, a registered
// 1-cycle read port, alignment/range fault reporting and a post-reset clear sweep.
module data_memory_sized #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  E,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  fault,
    output logic                  busy
);
    localparam int B    = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(B);
    localparam int IDXW = $clog2(DEPTH);
    localparam int SW   = $clog2(DATA_WIDTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_next;
    logic [IDXW-1:0]       clr_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [OFFW-1:0]       offset;
    logic [IDXW-1:0]       index;
    logic [3:0]            off4, size_bytes;
    logic                  out_of_range, misaligned, illegal, req, bad, ok;
    logic [B-1:0]          be;
    logic [DATA_WIDTH-1:0] wdata_sh, rword_sh, load_val;
    logic [SW-1:0]         sign_pos;
    logic                  sign;
    int                    nbits;

    assign busy         = (state == INIT);
    assign offset       = address[OFFW-1:0];
    assign index        = address[OFFW+IDXW-1:OFFW];
    assign off4         = 4'(offset);
    assign size_bytes   = 4'd1 << size;
    assign out_of_range = (address >> (OFFW + IDXW)) != '0;
    assign misaligned   = |(off4 & (size_bytes - 4'd1));
    assign illegal      = (DATA_WIDTH == 32) && (size == 2'b11);
    assign req          = E && !busy && (mem_read || mem_write);
    assign bad          = out_of_range || misaligned || illegal;
    assign ok           = req && !bad;

    // Lane l is written when it falls inside [offset, offset+size_bytes).
    always_comb begin
        be = '0;
        for (int l = 0; l < B; l++)
            be[l] = (4'(l) >= off4) && (4'(l) < off4 + size_bytes);
    end

    assign wdata_sh = write_data << {offset, 3'b000};
    assign rword_sh = mem[index] >> {offset, 3'b000};

    always_comb begin
        nbits = 8 << size;
        if (nbits > DATA_WIDTH) nbits = DATA_WIDTH;
        sign_pos = SW'(nbits - 1);
        sign     = !unsigned_ld && rword_sh[sign_pos];
        load_val = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            load_val[i] = (i < nbits) ? rword_sh[i] : sign;
    end

    always_comb begin
        state_next = state;
        if (state == INIT && clr_cnt == IDXW'(DEPTH - 1)) state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst)                clr_cnt <= '0;
        else if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            fault      <= 1'b0;
        end else begin
            read_valid <= ok && mem_read;
            fault      <= req && bad;
            if (ok && mem_read) read_data <= load_val;
        end
    end

    // The read path samples mem before this update, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT)
                mem[clr_cnt] <= '0;
            else if (ok && mem_write)
                for (int l = 0; l < B; l++)
                    if (be[l]) mem[index][8*l +: 8] <= wdata_sh[8*l +: 8];
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized + directed bench for data_memory_sized against a byte-array model.
module tb_data_memory_sized;
    localparam int DW = 64, DEPTH = 16, AW = 64, NB = DEPTH * 8;

    logic          clk = 0, rst = 1, E = 0, mem_write = 0, mem_read = 0, unsigned_ld = 0;
    logic [1:0]    size = 0;
    logic [AW-1:0] address = 0;
    logic [DW-1:0] write_data = 0;
    logic [DW-1:0] read_data;
    logic          read_valid, fault, busy;

    data_memory_sized #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .E(E), .address(address), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read), .size(size), .unsigned_ld(unsigned_ld),
        .read_data(read_data), .read_valid(read_valid), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: flat byte array, remaining-busy counter and expected registered outputs.
    logic [7:0]    mm [NB];
    int            busy_left = 0;
    logic [DW-1:0] exp_rd = 0;
    logic          exp_valid = 0, exp_fault = 0;
    bit            model_live = 0;

    function automatic bit model_fault(logic [AW-1:0] a, logic [1:0] sz);
        int nb = 1 << sz;
        return (a >= AW'(NB)) || ((a % AW'(nb)) != 0);
    endfunction

    function automatic logic [63:0] model_load(logic [AW-1:0] a, logic [1:0] sz, bit u);
        int nb = 1 << sz;
        int ia = int'(a);
        logic [63:0] v = 0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mm[ia + k];
        if (!u && nb < 8 && v[8*nb-1])
            for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            busy_left  <= DEPTH;
            exp_rd     <= 0;
            exp_valid  <= 0;
            exp_fault  <= 0;
            model_live <= 1;
            for (int i = 0; i < NB; i++) mm[i] <= 8'h00;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            exp_valid <= 0;
            exp_fault <= 0;
        end else if (E && (mem_read || mem_write)) begin
            if (model_fault(address, size)) begin
                exp_fault <= 1;
                exp_valid <= 0;
            end else begin
                exp_fault <= 0;
                exp_valid <= mem_read;
                if (mem_read) exp_rd <= model_load(address, size, unsigned_ld);
                if (mem_write)
                    for (int k = 0; k < (1 << size); k++)
                        mm[int'(address) + k] <= write_data[8*k +: 8];
            end
        end else begin
            exp_valid <= 0;
            exp_fault <= 0;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("busy", 64'(busy), 64'(busy_left != 0));
            chk("read_valid", 64'(read_valid), 64'(exp_valid));
            chk("fault", 64'(fault), 64'(exp_fault));
            chk("read_data", read_data, exp_rd);
        end
    end

    // Apply one request for one clock; on return the registered response is visible.
    task automatic drive(bit e, logic [AW-1:0] a, logic [DW-1:0] wd, bit wr, bit rd,
                         logic [1:0] sz, bit u);
        E = e; address = a; write_data = wd; mem_write = wr; mem_read = rd;
        size = sz; unsigned_ld = u;
        @(negedge clk);
        E = 0; mem_write = 0; mem_read = 0;
    endtask

    task automatic count_busy(string name);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(name, 64'(n), 64'd16);
    endtask

    task automatic pulse_rst();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_rd", read_data, 64'd0);
        rst = 0;
        count_busy("t1_busy_len");

        drive(1, 24, 0, 0, 1, 2'b11, 0);
        chk("t1_valid", 64'(read_valid), 64'd1);
        chk("t1_data", read_data, 64'd0);

        drive(1, 24, 48, 1, 0, 2'b11, 0);
        chk("t2_nofault", 64'(fault), 64'd0);
        drive(1, 24, 0, 0, 1, 2'b11, 0);
        chk("t2_data", read_data, 64'd48);
        chk("t2_valid", 64'(read_valid), 64'd1);

        drive(1, 27, 64'hFF, 1, 0, 2'b00, 0);
        drive(1, 24, 0, 0, 1, 2'b11, 0);
        chk("t3_dbl", read_data, 64'h00000000FF000030);
        chk("t3_dbl_model", exp_rd, 64'h00000000FF000030);
        drive(1, 27, 0, 0, 1, 2'b00, 0);
        chk("t3_sbyte", read_data, 64'hFFFFFFFFFFFFFFFF);
        chk("t3_sbyte_model", exp_rd, 64'hFFFFFFFFFFFFFFFF);
        drive(1, 27, 0, 0, 1, 2'b00, 1);
        chk("t3_ubyte", read_data, 64'h00000000000000FF);

        drive(1, 24, 28, 1, 1, 2'b11, 0);
        chk("t4_old", read_data, 64'h00000000FF000030);
        drive(1, 24, 0, 0, 1, 2'b11, 0);
        chk("t4_new", read_data, 64'd28);

        drive(0, 24, 99, 1, 0, 2'b11, 0);
        chk("t5_e0_fault", 64'(fault), 64'd0);
        chk("t5_e0_valid", 64'(read_valid), 64'd0);
        drive(1, 25, 64'h1234, 1, 0, 2'b01, 0);
        chk("t5_half_fault", 64'(fault), 64'd1);
        drive(1, 24, 0, 0, 1, 2'b11, 0);
        chk("t5_unchanged", read_data, 64'd28);
        drive(1, 128, 0, 0, 1, 2'b11, 0);
        chk("t5_oor_fault", 64'(fault), 64'd1);
        chk("t5_oor_valid", 64'(read_valid), 64'd0);
        chk("t5_oor_hold", read_data, 64'd28);

        pulse_rst();
        repeat (5) @(negedge clk);
        pulse_rst();
        count_busy("t6_busy_len");
        drive(1, 24, 77, 1, 0, 2'b11, 0);
        pulse_rst();
        count_busy("t6_busy_len2");
        drive(1, 24, 0, 0, 1, 2'b11, 0);
        chk("t6_cleared", read_data, 64'd0);

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            E           = ($urandom_range(0, 7) != 0);
            mem_write   = $urandom_range(0, 1);
            mem_read    = $urandom_range(0, 1);
            size        = 2'($urandom_range(0, 3));
            unsigned_ld = $urandom_range(0, 1);
            write_data  = {$urandom, $urandom};
            if ($urandom_range(0, 19) == 0) address = {32'($urandom_range(1, 3)), $urandom};
            else                            address = AW'($urandom_range(0, NB + 7));
            if ($urandom_range(0, 1) == 1) address = address & ~((AW'(1) << size) - 1);
            @(negedge clk);
        end
        rst = 0; E = 0; mem_write = 0; mem_read = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
